led_matrix_scanner: RTL and testbench

//  Downstream display stage of the maze game. Accepts one complete frame over a valid/ready handshake:
//  8x8 red map, 8x8 green cursor/smiley and 8 BCD digits (timer, steps).

---
 rtl/maze_disp_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 17 +
 rtl/led_matrix_scanner.sv | 137 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_disp_pkg.sv
// Shared types and lookup helpers for the maze game display stage.
package maze_disp_pkg;

  localparam int unsigned PIX_W = 64;
  localparam int unsigned BCD_W = 32;

  // One complete display frame as offered by the game core.
  typedef struct packed {
    logic [PIX_W-1:0] red;
    logic [PIX_W-1:0] grn;
    logic [BCD_W-1:0] bcd;
  } frame_t;

  // Empty frame: no pixels lit. Every digit is set to 4'hF so it shows blank.
  localparam frame_t FRAME_CLR = '{red: '0, grn: '0, bcd: '1};

  // BCD to {a,b,c,d,e,f,g,dp}, active-high; non-decimal codes blank.
  function automatic logic [7:0] seg7_lut(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Row/digit index to active-low one-hot strobe.
  function automatic logic [7:0] row_strobe(input logic [2:0] idx);
    return ~(8'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Registered BCD to seven-segment decoder (one cycle of latency).
module seg7_decode
  import maze_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Decode and register the segment pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg <= '0;
    else      seg <= seg7_lut(bcd);
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered row scanner for the 8x8 bicolour matrix and the 8-digit
// seven-segment display. A frame is accepted into the pending buffer and is
// committed to the active buffer only at the row 7 -> row 0 boundary.
// Optional feature macro: SCAN_BLINK_EN (per-pixel green blinking).
module led_matrix_scanner
  import maze_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 5000,
  parameter int unsigned BLANK_CYC  = 64
`ifdef SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_LOG2 = 9
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_valid,
  output logic        frm_ready,
  input  logic [63:0] frm_red,
  input  logic [63:0] frm_grn,
  input  logic [31:0] frm_bcd,
`ifdef SCAN_BLINK_EN
  input  logic [63:0] blink_mask,
`endif
  output logic        frm_start,
  output logic [7:0]  row,
  output logic [7:0]  r_col,
  output logic [7:0]  g_col,
  output logic [7:0]  digit_con,
  output logic [7:0]  digit_seg
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  // Elaboration guard: the blanking window must leave part of the slot lit.
  generate
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("BLANK_CYC must be less than SCAN_DIV");
    end
  endgenerate

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  frame_t           active, active_nxt, pend;
  logic             wrap, frame_end, accept, commit, lit;
  logic [7:0]       red_row, grn_row;
  logic [3:0]       digit, bcd_early;

`ifdef SCAN_BLINK_EN
  localparam int unsigned BLINK_W = BLINK_LOG2 + 1;

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic [63:0]        pend_mask, act_mask, act_mask_nxt;
  logic [7:0]         mask_row;
`endif

  // Next-state for the scan position, buffers and the pixel/digit selection.
  // Outputs are computed from next-state values so they register in step
  // with the slot counter.
  always_comb begin
    wrap       = (cnt == CNT_W'(SCAN_DIV - 1));
    frame_end  = wrap && (idx == 3'd7);
    cnt_nxt    = wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt    = wrap ? idx + 3'd1 : idx;
    accept     = frm_valid && frm_ready;
    commit     = frame_end && !frm_ready;
    active_nxt = commit ? pend : active;
    lit        = (cnt_nxt >= CNT_W'(BLANK_CYC));
    red_row    = active_nxt.red[{idx_nxt, 3'b000} +: 8];
    grn_row    = active_nxt.grn[{idx_nxt, 3'b000} +: 8];
    digit      = active_nxt.bcd[{idx_nxt, 2'b00} +: 4];
`ifdef SCAN_BLINK_EN
    blink_cnt_nxt = frame_end ? blink_cnt + BLINK_W'(1) : blink_cnt;
    act_mask_nxt  = commit ? pend_mask : act_mask;
    mask_row      = act_mask_nxt[{idx_nxt, 3'b000} +: 8];
    if (blink_cnt_nxt[BLINK_W-1]) grn_row = grn_row & ~mask_row;
`endif
    // The decoder adds a cycle, so it is fed the next slot position; 4'hF blanks.
    bcd_early  = lit ? digit : 4'hF;
  end

  // Scan position, frame buffers, handshake and registered drive outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      active    <= FRAME_CLR;
      pend      <= FRAME_CLR;
      frm_ready <= 1'b1;
      frm_start <= 1'b0;
      row       <= 8'hFF;
      digit_con <= 8'hFF;
      r_col     <= '0;
      g_col     <= '0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      active <= active_nxt;
      if (accept) begin
        pend      <= '{red: frm_red, grn: frm_grn, bcd: frm_bcd};
        frm_ready <= 1'b0;
      end else if (commit) begin
        pend      <= FRAME_CLR;
        frm_ready <= 1'b1;
      end
      frm_start <= frame_end;
      row       <= row_strobe(idx_nxt);
      digit_con <= row_strobe(idx_nxt);
      r_col     <= lit ? red_row : '0;
      g_col     <= lit ? grn_row : '0;
    end
  end

`ifdef SCAN_BLINK_EN
  // Blink phase counter and the blink mask travelling with each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      pend_mask <= '0;
      act_mask  <= '0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      act_mask  <= act_mask_nxt;
      if (accept)      pend_mask <= blink_mask;
      else if (commit) pend_mask <= '0;
    end
  end
`endif

  seg7_decode u_seg (
    .clk (clk),
    .rst (rst),
    .bcd (bcd_early),
    .seg (digit_seg)
  );

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with a shortened scan period
// (200-cycle slots, 64-cycle blanking, 1600-cycle frames).
module tb_led_matrix_scanner;

  localparam int unsigned SD = 200;
  localparam int unsigned BC = 64;
`ifdef SCAN_BLINK_EN
  localparam logic [7:0] BLINK_ROW1 = 8'hFD;
`else
  localparam logic [7:0] BLINK_ROW1 = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frm_valid;
  logic        frm_ready;
  logic [63:0] frm_red;
  logic [63:0] frm_grn;
  logic [31:0] frm_bcd;
  logic        frm_start;
  logic [7:0]  row;
  logic [7:0]  r_col;
  logic [7:0]  g_col;
  logic [7:0]  digit_con;
  logic [7:0]  digit_seg;
`ifdef SCAN_BLINK_EN
  logic [63:0] blink_mask = 64'h200;
`endif

  led_matrix_scanner #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
`ifdef SCAN_BLINK_EN
    ,
    .BLINK_LOG2(2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_red   (frm_red),
    .frm_grn   (frm_grn),
    .frm_bcd   (frm_bcd),
`ifdef SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .frm_start (frm_start),
    .row       (row),
    .r_col     (r_col),
    .g_col     (g_col),
    .digit_con (digit_con),
    .digit_seg (digit_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned k;
    logic        v;
    int unsigned f;
    logic [7:0]  row;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  seg;
    logic        rdy;
    logic        st;
  } vec_t;

  vec_t        tbl[$];
  int unsigned k;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] f_red[4];
  logic [63:0] f_grn[4];
  logic [31:0] f_bcd[4];

  task automatic add(input int unsigned kk, input logic v, input int unsigned f,
                     input logic [7:0] rw, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] seg, input logic rdy, input logic st);
    vec_t e;
    e.k = kk; e.v = v; e.f = f; e.row = rw; e.r = r; e.g = g;
    e.seg = seg; e.rdy = rdy; e.st = st;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto(input int unsigned target);
    while (k < target) tick();
  endtask

  task automatic drive(input logic v, input int unsigned f);
    frm_valid = v;
    frm_red   = f_red[f];
    frm_grn   = f_grn[f];
    frm_bcd   = f_bcd[f];
  endtask

  initial begin
    // Frame 1: red row3 A5, green row2 3C, digits d0=7 d3=C d5=5, rest blank.
    f_red[0] = '0; f_grn[0] = '0; f_bcd[0] = '1;
    f_red[1] = 64'h0000_0000_A500_0000;
    f_grn[1] = 64'h0000_0000_003C_0000;
    f_bcd[1] = 32'hFF5F_CFF7;
    // Frame 2: every red row 81, no green, d0=2 others 9.
    f_red[2] = 64'h8181_8181_8181_8181;
    f_grn[2] = '0;
    f_bcd[2] = 32'h9999_9992;
    // Frame 3: red row3 0F, green all on, d3=8 rest blank.
    f_red[3] = 64'h0000_0000_0F00_0000;
    f_grn[3] = '1;
    f_bcd[3] = 32'hFFFF_8FFF;

    rst = 1'b0;
    k   = 0;
    drive(1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    k = 0;

    //   k     v  f  row    r      g      seg    rdy st
    add(0,    1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
    add(1,    1, 2, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0);
    add(200,  1, 2, 8'hFD, 8'h00, 8'h00, 8'h00, 0, 0);
    add(663,  1, 2, 8'hF7, 8'h00, 8'h00, 8'h00, 0, 0);
    add(664,  1, 2, 8'hF7, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1400, 1, 2, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1599, 1, 2, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1600, 1, 2, 8'hFE, 8'h00, 8'h00, 8'h00, 1, 1);
    add(1601, 0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1663, 0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1664, 0, 0, 8'hFE, 8'h00, 8'h00, 8'hE0, 0, 0);
    add(2199, 0, 0, 8'hFB, 8'h00, 8'h3C, 8'h00, 0, 0);
    add(2263, 0, 0, 8'hF7, 8'h00, 8'h00, 8'h00, 0, 0);
    add(2264, 0, 0, 8'hF7, 8'hA5, 8'h00, 8'h00, 0, 0);
    add(2664, 0, 0, 8'hDF, 8'h00, 8'h00, 8'hB6, 0, 0);
    add(3199, 0, 0, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 0);
    add(3200, 0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 1, 1);
    add(3264, 0, 0, 8'hFE, 8'h81, 8'h00, 8'hDA, 1, 0);
    add(3464, 0, 0, 8'hFD, 8'h81, 8'h00, 8'hF6, 1, 0);
    add(4799, 1, 3, 8'h7F, 8'h81, 8'h00, 8'hF6, 1, 0);
    add(4800, 0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 1);
    add(4864, 0, 0, 8'hFE, 8'h81, 8'h00, 8'hDA, 0, 0);
    add(5464, 0, 0, 8'hF7, 8'h81, 8'h00, 8'hF6, 0, 0);
    add(6400, 0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 1, 1);
    add(6464, 0, 0, 8'hFE, 8'h00, 8'hFF, 8'h00, 1, 0);
    add(6664, 0, 0, 8'hFD, 8'h00, BLINK_ROW1, 8'h00, 1, 0);
    add(7000, 0, 0, 8'hF7, 8'h00, 8'h00, 8'h00, 1, 0);
    add(7064, 0, 0, 8'hF7, 8'h0F, 8'hFF, 8'hFE, 1, 0);

    foreach (tbl[i]) begin
      goto(tbl[i].k);
      chk("row",       row,       tbl[i].row);
      chk("digit_con", digit_con, tbl[i].row);
      chk("r_col",     r_col,     tbl[i].r);
      chk("g_col",     g_col,     tbl[i].g);
      chk("digit_seg", digit_seg, tbl[i].seg);
      chk("frm_ready", frm_ready, tbl[i].rdy);
      chk("frm_start", frm_start, tbl[i].st);
      drive(tbl[i].v, tbl[i].f);
    end

`ifdef SCAN_BLINK_EN
    // Blink phase returns to 0 after eight frames; row1 green fully lit again.
    goto(13064);
    chk("blink_phase0_g_col", g_col, 8'hFF);
`endif

    // Mid-operation reset with a frame pending: outputs drop at once, frame lost.
    drive(1'b1, 2);
    tick();
    chk("mr_ready_low", frm_ready, 1'b0);
    drive(1'b0, 0);
    #1 rst = 1'b0;
    #1;
    chk("mr_row",       row,       8'hFF);
    chk("mr_digit_con", digit_con, 8'hFF);
    chk("mr_r_col",     r_col,     8'h00);
    chk("mr_g_col",     g_col,     8'h00);
    chk("mr_digit_seg", digit_seg, 8'h00);
    chk("mr_frm_ready", frm_ready, 1'b1);
    chk("mr_frm_start", frm_start, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    k = 0;
    goto(664);
    chk("mr_act_clr_r", r_col, 8'h00);
    chk("mr_act_clr_g", g_col, 8'h00);
    chk("mr_act_clr_row", row, 8'hF7);
    goto(1600);
    chk("mr_start", frm_start, 1'b1);
    chk("mr_ready", frm_ready, 1'b1);
    goto(1664);
    chk("mr_lost_r",   r_col,     8'h00);
    chk("mr_lost_seg", digit_seg, 8'h00);
    chk("mr_lost_row", row,       8'hFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
